// File: rtl/rep_dec_pkg.sv
// rep_dec_pkg: FSM state encoding and frame/beat/sum width helpers for rep_decoder.
package rep_dec_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;
  function automatic int frame_w(input int out_w, input int rep, input int llr_w);
    return out_w * rep * llr_w;
  endfunction
  function automatic int beat_w(input int fw, input int beats);
    return fw / beats;
  endfunction
  function automatic int sum_w(input int llr_w, input int rep);
    return llr_w + $clog2(rep);
  endfunction
endpackage

// File: rtl/rep_dec_combiner.sv
// rep_dec_combiner: sign-extended sum of the REP soft LLRs belonging to one information bit.
module rep_dec_combiner
  import rep_dec_pkg::*;
#(
  parameter int LLR_W = 4,
  parameter int REP = 3,
  localparam int SUM_W = sum_w(LLR_W, REP)
) (
  input  logic [REP*LLR_W-1:0]    llrs,
  output logic signed [SUM_W-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int r = 0; r < REP; r++) sum = sum + SUM_W'($signed(llrs[r*LLR_W +: LLR_W]));
  end
endmodule

// File: rtl/rep_decoder.sv
// rep_decoder: loads a frame of soft LLRs in BEATS beats, then majority-decodes one bit per cycle.
// Define REP_DECODER_CONF_EN to add conf_o, the smallest |sum| seen across the frame.
module rep_decoder
  import rep_dec_pkg::*;
#(
  parameter int LLR_W = 4,
  parameter int REP = 3,
  parameter int OUT_W = 5,
  parameter int BEATS = 4,
  localparam int FRAME_W = frame_w(OUT_W, REP, LLR_W),
  localparam int BEAT_W = beat_w(FRAME_W, BEATS),
  localparam int SUM_W = sum_w(LLR_W, REP)
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [BEAT_W-1:0] data_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              overrun_o
`ifdef REP_DECODER_CONF_EN
  ,
  output logic [SUM_W-1:0]  conf_o
`endif
);
  localparam int GRP_W = REP * LLR_W;
  localparam int BC_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int IX_W = OUT_W > 1 ? $clog2(OUT_W) : 1;
  if (FRAME_W % BEATS != 0) begin : g_bad_beats
    $error("rep_decoder: frame width not divisible by BEATS");
  end
  if (REP < 2) begin : g_bad_rep
    $error("rep_decoder: REP must be at least 2");
  end
  state_t state, state_nx;
  logic [BC_W-1:0] beat_cnt;
  logic [IX_W-1:0] idx;
  logic [FRAME_W-1:0] frame;
  logic [GRP_W-1:0] grp;
  logic [OUT_W-1:0] dec, dec_nx;
  logic signed [SUM_W-1:0] sum;
  logic accept, last_beat, last_bit, neg;
  assign accept = start_i && (state == IDLE || state == LOAD);
  assign last_beat = beat_cnt == BC_W'(BEATS - 1);
  assign last_bit = idx == IX_W'(OUT_W - 1);
  assign neg = sum[SUM_W-1];
  assign done_o = state == DONE;
  assign busy_o = state != IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, LOAD: if (start_i) state_nx = last_beat ? ACC : LOAD;
      ACC:        if (last_bit) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    grp = '0;
    for (int b = 0; b < OUT_W; b++) if (idx == IX_W'(b)) grp = frame[b*GRP_W +: GRP_W];
  end
  always_comb begin
    dec_nx = dec;
    for (int b = 0; b < OUT_W; b++) if (idx == IX_W'(b)) dec_nx[b] = neg;
  end
  rep_dec_combiner #(.LLR_W(LLR_W), .REP(REP)) u_comb (.llrs(grp), .sum(sum));
  always_ff @(posedge clk_p_i or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_nx;
  // Frame storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_p_i)
    for (int j = 0; j < BEATS; j++)
      if (accept && beat_cnt == BC_W'(j)) frame[j*BEAT_W +: BEAT_W] <= data_i;
  always_ff @(posedge clk_p_i or negedge reset_n_i)
    if (!reset_n_i) begin
      beat_cnt  <= '0;
      idx       <= '0;
      dec       <= '0;
      data_o    <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= start_i && (state == ACC || state == DONE);
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (state == ACC) begin
        idx <= last_bit ? '0 : idx + 1'b1;
        dec <= dec_nx;
        if (last_bit) data_o <= dec_nx;
      end
    end
`ifdef REP_DECODER_CONF_EN
  logic [SUM_W-1:0] mag, min_q, min_nx;
  assign mag = neg ? -sum : sum;
  assign min_nx = (idx == '0 || mag < min_q) ? mag : min_q;
  always_ff @(posedge clk_p_i or negedge reset_n_i)
    if (!reset_n_i) begin
      min_q  <= '0;
      conf_o <= '0;
    end else if (state == ACC) begin
      min_q <= min_nx;
      if (last_bit) conf_o <= min_nx;
    end
`endif
endmodule

// File: tb/tb_rep_decoder.sv
// tb_rep_decoder: directed checks of rep_decoder at default parameters plus a REP=5/OUT_W=8/BEATS=1 sweep.
module tb_rep_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, start2 = 1'b0;
  logic [14:0] data = '0;
  logic [159:0] data2 = '0;
  logic [4:0] dout;
  logic [7:0] dout2;
  logic done, busy, overrun, done2, busy2, overrun2;
`ifdef REP_DECODER_CONF_EN
  logic [5:0] conf;
  logic [6:0] conf2;
`endif
  int checks = 0, passes = 0, done_cnt = 0;
  localparam logic [59:0] POS = {15{4'h7}};
  logic [59:0] mixed, tie;
  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt++;
  rep_decoder dut (
    .clk_p_i(clk), .reset_n_i(reset_n), .start_i(start), .data_i(data),
    .data_o(dout), .done_o(done), .busy_o(busy), .overrun_o(overrun)
`ifdef REP_DECODER_CONF_EN
    , .conf_o(conf)
`endif
  );
  rep_decoder #(.LLR_W(4), .REP(5), .OUT_W(8), .BEATS(1)) dut2 (
    .clk_p_i(clk), .reset_n_i(reset_n), .start_i(start2), .data_i(data2),
    .data_o(dout2), .done_o(done2), .busy_o(busy2), .overrun_o(overrun2)
`ifdef REP_DECODER_CONF_EN
    , .conf_o(conf2)
`endif
  );
  task automatic send_frame(input logic [59:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      data = f[i*15 +: 15];
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask
  // cyc counts cycles after the last beat; inj injects a stray beat in that cycle
  task automatic wait_done(input int inj, output int cyc, output int ovr);
    cyc = 1;
    ovr = 0;
    while (!done && cyc < 20) begin
      if (cyc == inj) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      ovr += int'(overrun);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout !== 5'd0) $display("FAIL reset_data got %b want 00000", dout); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passes++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_all_pos;
    int cyc, ovr;
    send_frame(POS, 0);
    checks++; if (busy !== 1'b1) $display("FAIL pos_busy got %b want 1", busy); else passes++;
    wait_done(0, cyc, ovr);
    checks++; if (cyc !== 6) $display("FAIL pos_latency got %0d want 6", cyc); else passes++;
    checks++; if (dout !== 5'b00000) $display("FAIL pos_data got %b want 00000", dout); else passes++;
`ifdef REP_DECODER_CONF_EN
    checks++; if (conf !== 6'd21) $display("FAIL pos_conf got %0d want 21", conf); else passes++;
`endif
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL pos_done_pulse got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL pos_idle_busy got %b want 0", busy); else passes++;
  endtask
  task automatic test_mixed;
    int cyc, ovr;
    send_frame(mixed, 0);
    wait_done(0, cyc, ovr);
    checks++; if (dout !== 5'b10001) $display("FAIL mixed_data got %b want 10001", dout); else passes++;
`ifdef REP_DECODER_CONF_EN
    checks++; if (conf !== 6'd1) $display("FAIL mixed_conf got %0d want 1", conf); else passes++;
`endif
    @(posedge clk); #1;
  endtask
  task automatic test_tie;
    int cyc, ovr;
    send_frame(tie, 0);
    wait_done(0, cyc, ovr);
    checks++; if (dout !== 5'b11011) $display("FAIL tie_data got %b want 11011", dout); else passes++;
`ifdef REP_DECODER_CONF_EN
    checks++; if (conf !== 6'd0) $display("FAIL tie_conf got %0d want 0", conf); else passes++;
`endif
    @(posedge clk); #1;
  endtask
  task automatic test_gaps_overrun;
    int cyc, ovr;
    send_frame(mixed, 2);
    data = 15'h7fff;
    wait_done(3, cyc, ovr);
    checks++; if (ovr !== 1) $display("FAIL gap_overrun_pulses got %0d want 1", ovr); else passes++;
    checks++; if (cyc !== 6) $display("FAIL gap_latency got %0d want 6", cyc); else passes++;
    checks++; if (dout !== 5'b10001) $display("FAIL gap_data got %b want 10001", dout); else passes++;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    int cyc, ovr;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      data = mixed[i*15 +: 15];
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", busy); else passes++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    done_cnt = 0;
    send_frame(POS, 0);
    wait_done(0, cyc, ovr);
    checks++; if (cyc !== 6 || done_cnt !== 0) $display("FAIL rmid_latency got %0d/%0d want 6/0", cyc, done_cnt); else passes++;
    checks++; if (dout !== 5'b00000) $display("FAIL rmid_data got %b want 00000", dout); else passes++;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 1) $display("FAIL rmid_done_count got %0d want 1", done_cnt); else passes++;
  endtask
  task automatic test_back_to_back;
    int cyc, ovr;
    send_frame(POS, 0);
    wait_done(0, cyc, ovr);
    start = 1'b1;
    data = mixed[14:0];
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got %b want 1", overrun); else passes++;
    send_frame(mixed, 0);
    wait_done(0, cyc, ovr);
    checks++; if (cyc !== 6) $display("FAIL b2b_latency got %0d want 6", cyc); else passes++;
    checks++; if (dout !== 5'b10001) $display("FAIL b2b_data got %b want 10001", dout); else passes++;
    @(posedge clk); #1;
  endtask
  task automatic test_sweep;
    logic [159:0] f;
    logic [7:0] exp_d;
    logic signed [3:0] x;
    int s, n;
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < 5; i++) f[i*32 +: 32] = $urandom;
      for (int b = 0; b < 8; b++) begin
        s = 0;
        for (int r = 0; r < 5; r++) begin
          x = f[(b*5+r)*4 +: 4];
          s += int'(x);
        end
        exp_d[b] = s < 0;
      end
      start2 = 1'b1;
      data2 = f;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 9 || dout2 !== exp_d) $display("FAIL sweep_%0d got %b@%0d want %b@9", t, dout2, n, exp_d);
      else passes++;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    mixed = {15{4'h3}};
    mixed[11:0] = {3{4'h8}};
    mixed[48 +: 12] = {4'h1, 4'hF, 4'hF};
    tie = {15{4'hE}};
    tie[24 +: 12] = {4'h0, 4'hF, 4'h1};
    test_reset;
    test_all_pos;
    test_mixed;
    test_tie;
    test_gaps_overrun;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
